// File: rtl/m2v_blkseq.sv
// MPEG-2 macroblock block sequencer: walks the coded blocks through the VLD and
// the scanner/dequantizer, and arbitrates quant-matrix loads.
// Optional macro M2V_BLKSEQ_CHROMA422_EN selects 8 blocks per macroblock instead of 6.
module m2v_blkseq #(
  parameter int EOB_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       softreset,
  input  logic       mb_start,
  input  logic [7:0] mb_cbp,
  input  logic       mb_intra,
  output logic       mb_busy,
  output logic       mb_done,
  input  logic       ready_isdq,
  output logic       block_start,
  output logic       block_end,
  output logic       blk_enable,
  output logic [2:0] blk_index,
  output logic       vld_start,
  input  logic       vld_eob,
  input  logic       qm_req,
  output logic       qm_grant,
  input  logic       qm_done,
  output logic       err_timeout
);

`ifdef M2V_BLKSEQ_CHROMA422_EN
  localparam logic [2:0] LAST_BLK = 3'd7;
`else
  localparam logic [2:0] LAST_BLK = 3'd5;
`endif

  localparam logic [7:0] TO_LIMIT = 8'(EOB_TIMEOUT);
  localparam bit         TO_EN    = (EOB_TIMEOUT != 0);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    GAP,
    DECODE,
    BLKEND,
    MBEND,
    QMLOAD
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cbp_q;
  logic       intra_q;
  logic [7:0] eob_cnt;
  logic       coded;
  logic       last_blk;
  logic       timeout_hit;

  // mb_cbp is MSB-aligned, so block N lives at bit 7-N
  assign coded       = intra_q | cbp_q[3'd7 - blk_index];
  assign last_blk    = (blk_index == LAST_BLK);
  assign timeout_hit = TO_EN && ((eob_cnt + 8'd1) == TO_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else if (softreset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    block_start = 1'b0;
    blk_enable  = 1'b0;
    vld_start   = 1'b0;
    case (state)
      IDLE: begin
        if (mb_start)
          state_nxt = WAIT_RDY;
        else if (qm_req)
          state_nxt = QMLOAD;
      end
      WAIT_RDY: begin
        if (ready_isdq) begin
          block_start = 1'b1;
          blk_enable  = coded;
          vld_start   = coded;
          state_nxt   = coded ? DECODE : GAP;
        end
      end
      GAP, BLKEND: state_nxt = last_blk ? MBEND : WAIT_RDY;
      DECODE: begin
        if (vld_eob || timeout_hit)
          state_nxt = BLKEND;
      end
      MBEND:   state_nxt = IDLE;
      QMLOAD: begin
        if (qm_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Level/pulse outputs are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mb_busy     <= 1'b0;
      mb_done     <= 1'b0;
      block_end   <= 1'b0;
      qm_grant    <= 1'b0;
      blk_index   <= 3'd0;
      cbp_q       <= 8'd0;
      intra_q     <= 1'b0;
      eob_cnt     <= 8'd0;
      err_timeout <= 1'b0;
    end else if (softreset) begin
      mb_busy     <= 1'b0;
      mb_done     <= 1'b0;
      block_end   <= 1'b0;
      qm_grant    <= 1'b0;
      blk_index   <= 3'd0;
      cbp_q       <= 8'd0;
      intra_q     <= 1'b0;
      eob_cnt     <= 8'd0;
      err_timeout <= 1'b0;
    end else begin
      mb_busy   <= (state_nxt != IDLE);
      mb_done   <= (state_nxt == MBEND);
      block_end <= (state_nxt == BLKEND);
      qm_grant  <= (state_nxt == QMLOAD);

      if (state == IDLE && mb_start) begin
        cbp_q   <= mb_cbp;
        intra_q <= mb_intra;
      end

      if (state_nxt == IDLE)
        blk_index <= 3'd0;
      else if ((state == GAP || state == BLKEND) && state_nxt == WAIT_RDY)
        blk_index <= blk_index + 3'd1;

      // Counter is zero in the first DECODE cycle and counts DECODE cycles spent
      if (state == WAIT_RDY)
        eob_cnt <= 8'd0;
      else if (state == DECODE)
        eob_cnt <= eob_cnt + 8'd1;

      if (state == DECODE && timeout_hit && !vld_eob)
        err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_m2v_blkseq.sv
// Directed bench for m2v_blkseq: table of macroblock patterns plus hand-written
// sequences for ready stall, EOB timeout, QM arbitration and softreset.
module tb_m2v_blkseq;

`ifdef M2V_BLKSEQ_CHROMA422_EN
  localparam int NBLK = 8;
`else
  localparam int NBLK = 6;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       softreset = 1'b0;
  logic       mb_start = 1'b0;
  logic [7:0] mb_cbp = 8'h00;
  logic       mb_intra = 1'b0;
  logic       ready_isdq = 1'b0;
  logic       vld_eob = 1'b0;
  logic       qm_req = 1'b0;
  logic       qm_done = 1'b0;
  logic       mb_busy, mb_done, block_start, block_end, blk_enable, vld_start;
  logic       qm_grant, err_timeout;
  logic [2:0] blk_index;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       intra;
    logic [7:0] cbp;
    logic [7:0] coded_mask;
  } mb_vec_t;

  mb_vec_t vecs[6];

  m2v_blkseq #(.EOB_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .softreset(softreset),
    .mb_start(mb_start), .mb_cbp(mb_cbp), .mb_intra(mb_intra),
    .mb_busy(mb_busy), .mb_done(mb_done), .ready_isdq(ready_isdq),
    .block_start(block_start), .block_end(block_end), .blk_enable(blk_enable),
    .blk_index(blk_index), .vld_start(vld_start), .vld_eob(vld_eob),
    .qm_req(qm_req), .qm_grant(qm_grant), .qm_done(qm_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic soft_reset_pulse();
    @(negedge clk);
    softreset = 1'b1;
    @(negedge clk);
    softreset = 1'b0;
  endtask

  // One macroblock with ready always high and vld_eob 10 cycles after each vld_start
  task automatic apply_stimulus(input int id, input mb_vec_t v);
    int eob_at, n_bs, n_be, n_done, n_stray, last_bs, min_gap, exp_coded, exp_en;
    exp_coded = 0;
    for (int i = 0; i < NBLK; i++) exp_coded += int'(v.coded_mask[i]);
    eob_at = -1; n_bs = 0; n_be = 0; n_done = 0; n_stray = 0;
    last_bs = -100; min_gap = 1000;
    @(negedge clk);
    mb_start = 1'b1; mb_cbp = v.cbp; mb_intra = v.intra; ready_isdq = 1'b1;
    @(negedge clk);
    mb_start = 1'b0; mb_cbp = 8'h00; mb_intra = 1'b0;
    for (int cyc = 0; cyc < 400 && n_done == 0; cyc++) begin
      vld_eob = (cyc == eob_at);
      #1;
      if (block_start) begin
        exp_en = (n_bs < NBLK) ? int'(v.coded_mask[n_bs]) : 0;
        check_output($sformatf("vec%0d blk%0d index", id, n_bs), int'(blk_index), n_bs);
        check_output($sformatf("vec%0d blk%0d enable", id, n_bs), int'(blk_enable), exp_en);
        check_output($sformatf("vec%0d blk%0d vld_start", id, n_bs), int'(vld_start), exp_en);
        if (cyc - last_bs < min_gap) min_gap = cyc - last_bs;
        last_bs = cyc;
        if (vld_start) eob_at = cyc + 10;
        n_bs++;
      end else if (vld_start) begin
        n_stray++;
      end
      if (block_end) begin
        n_be++;
        check_output($sformatf("vec%0d block_end latency", id), cyc, eob_at + 1);
      end
      if (mb_done) n_done++;
      @(negedge clk);
    end
    vld_eob = 1'b0;
    #1;
    check_output($sformatf("vec%0d block_start count", id), n_bs, NBLK);
    check_output($sformatf("vec%0d block_end count", id), n_be, exp_coded);
    check_output($sformatf("vec%0d mb_done count", id), n_done, 1);
    check_output($sformatf("vec%0d stray vld_start", id), n_stray, 0);
    check_output($sformatf("vec%0d min spacing ok", id), int'(min_gap >= 2), 1);
    check_output($sformatf("vec%0d busy after", id), int'(mb_busy), 0);
    check_output($sformatf("vec%0d index after", id), int'(blk_index), 0);
  endtask

  initial begin
    int cnt, found;

    vecs[0] = '{intra: 1'b1, cbp: 8'h00, coded_mask: 8'hFF};
    vecs[1] = '{intra: 1'b0, cbp: 8'hA0, coded_mask: 8'h05};
    vecs[2] = '{intra: 1'b0, cbp: 8'h00, coded_mask: 8'h00};
    vecs[3] = '{intra: 1'b0, cbp: 8'hFC, coded_mask: 8'h3F};
    vecs[4] = '{intra: 1'b0, cbp: 8'h03, coded_mask: 8'hC0};
    vecs[5] = '{intra: 1'b0, cbp: 8'h14, coded_mask: 8'h28};

    repeat (3) @(negedge clk);
    ready_isdq = 1'b1;
    #1;
    check_output("reset busy", int'(mb_busy), 0);
    check_output("reset block_start", int'(block_start), 0);
    check_output("reset qm_grant", int'(qm_grant), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check_output("idle busy", int'(mb_busy), 0);
    check_output("idle mb_done", int'(mb_done), 0);
    check_output("idle block_end", int'(block_end), 0);
    check_output("idle err_timeout", int'(err_timeout), 0);
    check_output("idle blk_index", int'(blk_index), 0);
    check_output("idle vld_start", int'(vld_start), 0);

    // ready_isdq stalled for 20 cycles, then softreset mid-DECODE
    @(negedge clk);
    mb_start = 1'b1; mb_intra = 1'b1; mb_cbp = 8'h00; ready_isdq = 1'b0;
    @(negedge clk);
    mb_start = 1'b0; mb_intra = 1'b0;
    cnt = 0;
    repeat (20) begin
      #1;
      if (block_start) cnt++;
      @(negedge clk);
    end
    check_output("stall no block_start", cnt, 0);
    check_output("stall busy", int'(mb_busy), 1);
    ready_isdq = 1'b1;
    #1;
    check_output("stall release block_start", int'(block_start), 1);
    check_output("stall release enable", int'(blk_enable), 1);
    check_output("stall release vld_start", int'(vld_start), 1);
    repeat (4) @(negedge clk);
    softreset = 1'b1;
    @(negedge clk);
    softreset = 1'b0;
    #1;
    check_output("abort busy", int'(mb_busy), 0);
    cnt = 0;
    repeat (15) begin
      #1;
      if (block_end || mb_done || block_start) cnt++;
      @(negedge clk);
    end
    check_output("abort no pulses", cnt, 0);

    // No vld_eob: forced end after 16 DECODE cycles
    mb_start = 1'b1; mb_intra = 1'b1;
    @(negedge clk);
    mb_start = 1'b0; mb_intra = 1'b0;
    #1;
    check_output("timeout vld_start", int'(vld_start), 1);
    found = -1;
    for (int i = 1; i <= 40 && found < 0; i++) begin
      @(negedge clk);
      #1;
      if (block_end) found = i;
    end
    check_output("timeout block_end cycle", found, 17);
    check_output("timeout err set", int'(err_timeout), 1);
    repeat (3) @(negedge clk);
    #1;
    check_output("timeout err sticky", int'(err_timeout), 1);
    soft_reset_pulse();
    #1;
    check_output("timeout err cleared", int'(err_timeout), 0);

    // vld_eob on the very cycle the timeout would fire
    @(negedge clk);
    mb_start = 1'b1; mb_intra = 1'b1;
    @(negedge clk);
    mb_start = 1'b0; mb_intra = 1'b0;
    found = -1;
    for (int i = 1; i <= 40 && found < 0; i++) begin
      @(negedge clk);
      vld_eob = (i == 16);
      #1;
      if (block_end) found = i;
    end
    vld_eob = 1'b0;
    check_output("coincident block_end cycle", found, 17);
    check_output("coincident err clear", int'(err_timeout), 0);
    soft_reset_pulse();

    // qm_req together with mb_start: macroblock first, then QM load
    @(negedge clk);
    mb_start = 1'b1; qm_req = 1'b1; mb_cbp = 8'h00; mb_intra = 1'b0;
    @(negedge clk);
    mb_start = 1'b0;
    cnt = 0; found = -1;
    for (int i = 0; i < 60 && found < 0; i++) begin
      #1;
      if (qm_grant) cnt++;
      if (mb_done) found = i;
      @(negedge clk);
    end
    check_output("arb mb_done cycle", found, 12);
    check_output("arb no early grant", cnt, 0);
    #1;
    check_output("arb idle grant", int'(qm_grant), 0);
    check_output("arb idle index", int'(blk_index), 0);
    @(negedge clk);
    #1;
    check_output("arb grant", int'(qm_grant), 1);
    qm_req = 1'b0;
    repeat (3) @(negedge clk);
    qm_done = 1'b1;
    #1;
    check_output("arb grant held", int'(qm_grant), 1);
    @(negedge clk);
    qm_done = 1'b0;
    #1;
    check_output("arb grant dropped", int'(qm_grant), 0);
    check_output("arb busy dropped", int'(mb_busy), 0);

    // softreset while the QM path is granted
    @(negedge clk);
    qm_req = 1'b1;
    @(negedge clk);
    qm_req = 1'b0;
    #1;
    check_output("qm abort grant before", int'(qm_grant), 1);
    soft_reset_pulse();
    #1;
    check_output("qm abort grant", int'(qm_grant), 0);
    check_output("qm abort busy", int'(mb_busy), 0);

    for (int k = 0; k < 6; k++) apply_stimulus(k, vecs[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
